alu_issue_stage: RTL and testbench
==================================

# alu_issue_stage

Decode-and-issue stage that drives the ALU's operand and operation inputs. Each valid instruction word is decoded into the 6-bit ALU operation code and the selected A/B operands, and the result is registered as the ID/EX pipeline register. The ALU then consumes these registered outputs combinationally in EX. The stage has stall and flush controls so the hazard unit can hold it or insert a bubble.

## Interface
- `NB_DATA`, 32: operand and instruction width.
- `NB_ALU_OP`, 6: ALU operation code width.
- `NB_REG`, 5: register address width.
- `i_clk` input 1: clock; all state updates on the rising edge.
- `i_reset` input 1: synchronous, active-high reset.
- `i_valid` input 1: `i_instr` and the operands are valid this cycle.
- `i_stall` input 1: hold every output register.
- `i_flush` input 1: load a bubble.
- `i_instr` input `NB_DATA`: instruction word.
- `i_pc` input `NB_DATA`: address of the instruction.
- `i_rs_data` input `NB_DATA`: value read from register rs.
- `i_rt_data` input `NB_DATA`: value read from register rt.
- `o_valid` output 1: the EX stage holds a real instruction.
- `o_alu_op` output `NB_ALU_OP`: drives the ALU operation input.
- `o_dato_a` output `NB_DATA`: drives ALU operand A.
- `o_dato_b` output `NB_DATA`: drives ALU operand B.
- `o_rd_addr` output `NB_REG`: destination register.
- `o_reg_write` output 1: write-back enable.
- `o_illegal` output 1: illegal-instruction flag (see Configuration).

## Operation
- Register update priority: `i_reset` > `i_flush` > `i_stall` > load.
  - A load occurs when `i_valid` is high; `!i_valid` without stall loads a bubble.
- A bubble sets `o_valid`=0, `o_alu_op`=6'b111111 (the ALU returns 0 for this code), operands 0, `o_rd_addr`=0, `o_reg_write`=0.
- R-type (opcode 000000):
  - `o_alu_op` = funct for funct ∈ {100001, 100011, 100100, 100101, 100110, 100111, 101010}.
  - For these: A = rs, B = rt, destination = rd.
  - sll/srl/sra (funct 000000/000010/000011): A = {27'b0, shamt[10:6]}, B = rt.
  - sllv/srlv/srav (000100/000110/000111): A = {27'b0, rs[4:0]}, B = rt.
  - jalr (001001): op 001001, A = `i_pc`, B = 0, destination = rd. The ALU produces pc+4.
- I-type (destination = rt):
  - addiu 001001 → op 100001, B = sign-extended imm.
  - slti 001010 → op 101010, B = sign-extended imm.
  - andi 001100 → op 100100, B = zero-extended imm.
  - ori 001101 → op 100101, B = zero-extended imm.
  - xori 001110 → op 100110, B = zero-extended imm.
  - lui 001111 → op 001111, B = zero-extended imm.
  - A = rs for all I-type instructions.
- jal (000011): op 001001, A = `i_pc`, B = 0, destination = 31.
- Write enable: `o_reg_write` = valid decode AND destination ≠ 0. A write to r0 is never enabled.
- Any other opcode or funct is illegal. It is issued as a bubble with `o_valid`=1 and `o_alu_op`=6'b111111.

## Timing
- Latency is 1 cycle: an instruction sampled at edge N appears on all outputs after edge N.
- Reset values: `o_valid`=0, `o_alu_op`=6'b111111, `o_dato_a`=`o_dato_b`=0, `o_rd_addr`=0, `o_reg_write`=0, `o_illegal`=0, illegal counter=0.
- Stall: the outputs keep their previous values for every cycle `i_stall` is high, whatever `i_valid` and `i_instr` are doing.
- Flush together with stall: flush wins, and a bubble is loaded.
- Reset in the middle of a stall: the reset values apply on the next edge.

## Configuration
- `ALU_ISSUE_ILLEGAL_TRAP_EN`
  - Defined:
    - `o_illegal` is sticky. It is set on the edge that loads an illegal instruction and cleared only by `i_reset`.
    - An internal 8-bit counter of illegal loads saturates at 255.
    - Stalled or flushed cycles do not count.
  - Undefined:
    - Illegal instructions issue silently as described in Operation.
    - `o_illegal` is tied to 0 and no counter exists.

## Test plan
- Reset, then addiu 0x2528FFFF with rs=5 → next cycle: op 100001, A=5, B=0xFFFFFFFF, rd=8, reg_write=1, valid=1.
- sll 0x000B5100 with rt=0x3 → op 000000, A=4, B=3, rd=10, reg_write=1.
- lui 0x3C081234, then jal at pc=0x100 → first: op 001111, B=0x00001234, rd=8; then: op 001001, A=0x100, rd=31.
- Load addu (rd=0), then stall 3 cycles while changing `i_instr` → reg_write=0 and outputs unchanged through the stall. Assert flush and stall together → bubble (valid=0, op 111111).
- Illegal opcode 0xFC000000 twice → op 111111, reg_write=0.
  - With the macro: `o_illegal` stays 1 and the counter reads 2 until reset.
  - Without the macro: `o_illegal` stays 0.

Source files
------------

// File: rtl/alu_issue_if.sv
// alu_issue_if: issue-stage bus between decode/hazard logic (master) and the ID/EX register (slave)
//   i_valid/i_stall/i_flush : handshake and hazard controls
//   i_instr/i_pc            : instruction word and its address
//   i_rs_data/i_rt_data     : register-file read values
//   o_*                     : registered ALU drive (valid, op, operands, rd, reg_write, illegal)
interface alu_issue_if #(
    parameter int NB_DATA   = 32,
    parameter int NB_ALU_OP = 6,
    parameter int NB_REG    = 5
);
    logic                 i_valid;
    logic                 i_stall;
    logic                 i_flush;
    logic [NB_DATA-1:0]   i_instr;
    logic [NB_DATA-1:0]   i_pc;
    logic [NB_DATA-1:0]   i_rs_data;
    logic [NB_DATA-1:0]   i_rt_data;
    logic                 o_valid;
    logic [NB_ALU_OP-1:0] o_alu_op;
    logic [NB_DATA-1:0]   o_dato_a;
    logic [NB_DATA-1:0]   o_dato_b;
    logic [NB_REG-1:0]    o_rd_addr;
    logic                 o_reg_write;
    logic                 o_illegal;
    modport master (
        output i_valid, i_stall, i_flush, i_instr, i_pc, i_rs_data, i_rt_data,
        input  o_valid, o_alu_op, o_dato_a, o_dato_b, o_rd_addr, o_reg_write, o_illegal
    );
    modport slave (
        input  i_valid, i_stall, i_flush, i_instr, i_pc, i_rs_data, i_rt_data,
        output o_valid, o_alu_op, o_dato_a, o_dato_b, o_rd_addr, o_reg_write, o_illegal
    );
endinterface

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: decodes instructions into ALU op/operands and registers them as ID/EX
//   i_clk, i_reset : clock, synchronous active-high reset
//   bus (slave)    : instruction/operand inputs, stall/flush, registered ALU drive outputs
//   ALU_ISSUE_ILLEGAL_TRAP_EN : sticky o_illegal plus saturating illegal-load counter
module alu_issue_stage #(
    parameter int NB_DATA   = 32,
    parameter int NB_ALU_OP = 6,
    parameter int NB_REG    = 5
) (
    input logic        i_clk,
    input logic        i_reset,
    alu_issue_if.slave bus
);
    localparam logic [NB_ALU_OP-1:0] OP_NOP = '1;
    logic [5:0]           opcode, funct;
    logic [NB_REG-1:0]    rs_f, rt_f, rd_f;
    logic [NB_DATA-1:0]   imm_sext, imm_zext;
    logic                 dec_legal;
    logic [NB_ALU_OP-1:0] dec_op;
    logic [NB_DATA-1:0]   dec_a, dec_b;
    logic [NB_REG-1:0]    dec_rd;
    logic                 load_bubble, load_instr;
    logic                 valid_d, valid_q, we_d, we_q;
    logic [NB_ALU_OP-1:0] op_d, op_q;
    logic [NB_DATA-1:0]   a_d, a_q, b_d, b_q;
    logic [NB_REG-1:0]    rd_d, rd_q;
    assign opcode   = bus.i_instr[31:26];
    assign funct    = bus.i_instr[5:0];
    assign rs_f     = bus.i_instr[25:21];
    assign rt_f     = bus.i_instr[20:16];
    assign rd_f     = bus.i_instr[15:11];
    assign imm_sext = {{(NB_DATA-16){bus.i_instr[15]}}, bus.i_instr[15:0]};
    assign imm_zext = {{(NB_DATA-16){1'b0}}, bus.i_instr[15:0]};
    always_comb begin
        dec_legal = 1'b1;
        dec_op    = OP_NOP;
        dec_a     = '0;
        dec_b     = '0;
        dec_rd    = '0;
        // I-type share A = rs and destination = rt; unsupported opcodes in this group fall to illegal below
        if (opcode[5:3] == 3'b001) begin
            dec_a  = bus.i_rs_data;
            dec_rd = rt_f;
        end
        case (opcode)
            6'b000000: begin
                dec_op = NB_ALU_OP'(funct);
                dec_b  = bus.i_rt_data;
                dec_rd = rd_f;
                case (funct)
                    6'b100001, 6'b100011, 6'b100100, 6'b100101,
                    6'b100110, 6'b100111, 6'b101010: dec_a = bus.i_rs_data;
                    6'b000000, 6'b000010, 6'b000011: dec_a = {{(NB_DATA-5){1'b0}}, bus.i_instr[10:6]};
                    6'b000100, 6'b000110, 6'b000111: dec_a = {{(NB_DATA-5){1'b0}}, bus.i_rs_data[4:0]};
                    6'b001001: begin
                        dec_a = bus.i_pc;
                        dec_b = '0;
                    end
                    default: dec_legal = 1'b0;
                endcase
            end
            6'b001001: begin dec_op = 6'b100001; dec_b = imm_sext; end
            6'b001010: begin dec_op = 6'b101010; dec_b = imm_sext; end
            6'b001100: begin dec_op = 6'b100100; dec_b = imm_zext; end
            6'b001101: begin dec_op = 6'b100101; dec_b = imm_zext; end
            6'b001110: begin dec_op = 6'b100110; dec_b = imm_zext; end
            6'b001111: begin dec_op = 6'b001111; dec_b = imm_zext; end
            6'b000011: begin
                dec_op = 6'b001001;
                dec_a  = bus.i_pc;
                dec_rd = '1;
            end
            default: dec_legal = 1'b0;
        endcase
    end
    assign load_bubble = bus.i_flush || (!bus.i_stall && !bus.i_valid);
    assign load_instr  = !bus.i_flush && !bus.i_stall && bus.i_valid;
    always_comb begin
        valid_d = valid_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        rd_d    = rd_q;
        we_d    = we_q;
        // illegal instructions issue as a valid bubble
        if (load_bubble || (load_instr && !dec_legal)) begin
            valid_d = load_instr;
            op_d    = OP_NOP;
            a_d     = '0;
            b_d     = '0;
            rd_d    = '0;
            we_d    = 1'b0;
        end else if (load_instr) begin
            valid_d = 1'b1;
            op_d    = dec_op;
            a_d     = dec_a;
            b_d     = dec_b;
            rd_d    = dec_rd;
            we_d    = |dec_rd;
        end
    end
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            valid_q <= 1'b0;
            op_q    <= OP_NOP;
            a_q     <= '0;
            b_q     <= '0;
            rd_q    <= '0;
            we_q    <= 1'b0;
        end else begin
            valid_q <= valid_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            rd_q    <= rd_d;
            we_q    <= we_d;
        end
    end
    assign bus.o_valid     = valid_q;
    assign bus.o_alu_op    = op_q;
    assign bus.o_dato_a    = a_q;
    assign bus.o_dato_b    = b_q;
    assign bus.o_rd_addr   = rd_q;
    assign bus.o_reg_write = we_q;
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
    logic       illegal_hit, illegal_d, illegal_q;
    logic [7:0] illegal_cnt_d, illegal_cnt_q;
    always_comb begin
        illegal_hit   = load_instr && !dec_legal;
        illegal_d     = illegal_q | illegal_hit;
        illegal_cnt_d = (illegal_hit && illegal_cnt_q != 8'hFF) ? illegal_cnt_q + 8'd1 : illegal_cnt_q;
    end
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            illegal_q     <= 1'b0;
            illegal_cnt_q <= 8'd0;
        end else begin
            illegal_q     <= illegal_d;
            illegal_cnt_q <= illegal_cnt_d;
        end
    end
    assign bus.o_illegal = illegal_q;
`else
    assign bus.o_illegal = 1'b0;
`endif
endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage: scoreboard bench for alu_issue_stage
module tb_alu_issue_stage;
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif
    typedef struct packed {
        logic        v;
        logic [5:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic        we;
        logic        ill;
    } out_t;
    typedef struct packed {
        logic        rst, v, st, fl;
        logic [31:0] instr, pc, rs, rt;
    } stim_t;
    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;
    out_t sb[$];
    out_t got, exp_o;
    alu_issue_if bus();
    alu_issue_stage dut (.i_clk(clk), .i_reset(rst), .bus(bus));
    always #5 clk = ~clk;
    function automatic stim_t S(input logic r, v, st, fl, input logic [31:0] instr, pc, rs, rt);
        return '{rst: r, v: v, st: st, fl: fl, instr: instr, pc: pc, rs: rs, rt: rt};
    endfunction
    function automatic out_t E(input logic v, input logic [5:0] op, input logic [31:0] a, b,
                               input logic [4:0] rd, input logic we, ill);
        return '{v: v, op: op, a: a, b: b, rd: rd, we: we, ill: ill};
    endfunction
    function automatic out_t obs();
        return '{v: bus.o_valid, op: bus.o_alu_op, a: bus.o_dato_a, b: bus.o_dato_b,
                 rd: bus.o_rd_addr, we: bus.o_reg_write, ill: bus.o_illegal};
    endfunction
    task automatic issue(input stim_t s, input out_t e);
        rst           = s.rst;
        bus.i_valid   = s.v;
        bus.i_stall   = s.st;
        bus.i_flush   = s.fl;
        bus.i_instr   = s.instr;
        bus.i_pc      = s.pc;
        bus.i_rs_data = s.rs;
        bus.i_rt_data = s.rt;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask
    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            issue(S(1, 1, 0, 0, 32'h2528FFFF, 0, 5, 0), E(0, 6'h3F, 0, 0, 0, 0, 0));
            got = obs(); exp_o = sb.pop_front(); n_cmp++;
            if (got !== exp_o) begin
                n_err++;
                $display("FAIL reset got=%h exp=%h", got, exp_o);
            end
        end
    endtask
    task automatic test_itype();
        stim_t st[$];
        out_t  ex[$];
        st.push_back(S(0, 1, 0, 0, 32'h2528FFFF, 0, 5, 0));          ex.push_back(E(1, 6'h21, 5, 32'hFFFFFFFF, 8, 1, 0));
        st.push_back(S(0, 1, 0, 0, 32'h3C081234, 0, 0, 0));          ex.push_back(E(1, 6'h0F, 0, 32'h00001234, 8, 1, 0));
        st.push_back(S(0, 1, 0, 0, 32'h3109F0F0, 0, 32'hFFFF0000, 0)); ex.push_back(E(1, 6'h24, 32'hFFFF0000, 32'h0000F0F0, 9, 1, 0));
        st.push_back(S(0, 1, 0, 0, 32'h2800FFFE, 0, 32'h11, 0));      ex.push_back(E(1, 6'h2A, 32'h11, 32'hFFFFFFFE, 0, 0, 0));
        st.push_back(S(0, 1, 0, 0, 32'h3509F0F0, 0, 32'h10, 0));      ex.push_back(E(1, 6'h25, 32'h10, 32'h0000F0F0, 9, 1, 0));
        foreach (st[i]) begin
            issue(st[i], ex[i]);
            got = obs(); exp_o = sb.pop_front(); n_cmp++;
            if (got !== exp_o) begin
                n_err++;
                $display("FAIL itype[%0d] got=%h exp=%h", i, got, exp_o);
            end
        end
    endtask
    task automatic test_rtype();
        stim_t st[$];
        out_t  ex[$];
        st.push_back(S(0, 1, 0, 0, 32'h000B5100, 0, 32'h77, 3));          ex.push_back(E(1, 6'h00, 4, 3, 10, 1, 0));
        st.push_back(S(0, 1, 0, 0, 32'h00432004, 0, 32'hFFFFFFE5, 32'h80000000)); ex.push_back(E(1, 6'h04, 5, 32'h80000000, 4, 1, 0));
        st.push_back(S(0, 1, 0, 0, 32'h0022182A, 0, 10, 20));             ex.push_back(E(1, 6'h2A, 10, 20, 3, 1, 0));
        st.push_back(S(0, 1, 0, 0, 32'h03E0F809, 32'h200, 32'h55, 32'h66)); ex.push_back(E(1, 6'h09, 32'h200, 0, 31, 1, 0));
        st.push_back(S(0, 1, 0, 0, 32'h0C000040, 32'h100, 32'h55, 32'h66)); ex.push_back(E(1, 6'h09, 32'h100, 0, 31, 1, 0));
        foreach (st[i]) begin
            issue(st[i], ex[i]);
            got = obs(); exp_o = sb.pop_front(); n_cmp++;
            if (got !== exp_o) begin
                n_err++;
                $display("FAIL rtype[%0d] got=%h exp=%h", i, got, exp_o);
            end
        end
    endtask
    task automatic test_stall_flush();
        stim_t st[$];
        out_t  ex[$];
        out_t  addu_o = E(1, 6'h21, 7, 9, 0, 0, 0);
        st.push_back(S(0, 1, 0, 0, 32'h00850021, 0, 7, 9));          ex.push_back(addu_o);
        st.push_back(S(0, 1, 1, 0, 32'h3C081234, 0, 1, 2));          ex.push_back(addu_o);
        st.push_back(S(0, 0, 1, 0, 32'h2528FFFF, 0, 3, 4));          ex.push_back(addu_o);
        st.push_back(S(0, 1, 1, 0, 32'hFC000000, 0, 5, 6));          ex.push_back(addu_o);
        st.push_back(S(0, 1, 1, 1, 32'h2528FFFF, 0, 5, 0));          ex.push_back(E(0, 6'h3F, 0, 0, 0, 0, 0));
        st.push_back(S(0, 1, 0, 0, 32'h2528FFFF, 0, 5, 0));          ex.push_back(E(1, 6'h21, 5, 32'hFFFFFFFF, 8, 1, 0));
        st.push_back(S(0, 0, 0, 0, 32'h2528FFFF, 0, 5, 0));          ex.push_back(E(0, 6'h3F, 0, 0, 0, 0, 0));
        foreach (st[i]) begin
            issue(st[i], ex[i]);
            got = obs(); exp_o = sb.pop_front(); n_cmp++;
            if (got !== exp_o) begin
                n_err++;
                $display("FAIL stall_flush[%0d] got=%h exp=%h", i, got, exp_o);
            end
        end
    endtask
    task automatic test_illegal();
        stim_t st[$];
        out_t  ex[$];
        out_t  ill_o = E(1, 6'h3F, 0, 0, 0, 0, TRAP);
        st.push_back(S(0, 1, 0, 0, 32'hFC000000, 0, 5, 6));          ex.push_back(ill_o);
        st.push_back(S(0, 1, 0, 0, 32'hFC000000, 0, 5, 6));          ex.push_back(ill_o);
        st.push_back(S(0, 1, 1, 0, 32'hFC000000, 0, 5, 6));          ex.push_back(ill_o);
        st.push_back(S(0, 1, 0, 1, 32'hFC000000, 0, 5, 6));          ex.push_back(E(0, 6'h3F, 0, 0, 0, 0, TRAP));
        st.push_back(S(0, 1, 0, 0, 32'h2528FFFF, 0, 5, 0));          ex.push_back(E(1, 6'h21, 5, 32'hFFFFFFFF, 8, 1, TRAP));
        st.push_back(S(0, 1, 0, 0, 32'h0085003F, 0, 5, 6));          ex.push_back(ill_o);
        foreach (st[i]) begin
            issue(st[i], ex[i]);
            got = obs(); exp_o = sb.pop_front(); n_cmp++;
            if (got !== exp_o) begin
                n_err++;
                $display("FAIL illegal[%0d] got=%h exp=%h", i, got, exp_o);
            end
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
            n_cmp++;
            if (dut.illegal_cnt_q !== ((i < 5) ? 8'd2 - 8'(i == 0) : 8'd3)) begin
                n_err++;
                $display("FAIL illegal_cnt[%0d] got=%0d exp=%0d", i, dut.illegal_cnt_q, (i < 5) ? 2 - int'(i == 0) : 3);
            end
`endif
        end
    endtask
    task automatic test_reset_in_stall();
        issue(S(0, 1, 0, 0, 32'h2528FFFF, 0, 5, 0), E(1, 6'h21, 5, 32'hFFFFFFFF, 8, 1, TRAP));
        issue(S(1, 1, 1, 0, 32'h3C081234, 0, 1, 2), E(0, 6'h3F, 0, 0, 0, 0, 0));
        for (int i = 0; i < 2; i++) begin
            got = obs(); exp_o = sb.pop_front(); n_cmp++;
            if (i == 1 && got !== exp_o) begin
                n_err++;
                $display("FAIL reset_in_stall got=%h exp=%h", got, exp_o);
            end
        end
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
        n_cmp++;
        if (dut.illegal_cnt_q !== 8'd0) begin
            n_err++;
            $display("FAIL cnt_after_reset got=%0d exp=0", dut.illegal_cnt_q);
        end
`endif
    endtask
    task automatic test_saturation();
        for (int i = 0; i < 260; i++) begin
            issue(S(0, 1, 0, 0, 32'hFC000000, 0, 0, 0), E(1, 6'h3F, 0, 0, 0, 0, TRAP));
            got = obs(); exp_o = sb.pop_front(); n_cmp++;
            if (got !== exp_o) begin
                n_err++;
                $display("FAIL saturation[%0d] got=%h exp=%h", i, got, exp_o);
            end
        end
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
        n_cmp++;
        if (dut.illegal_cnt_q !== 8'd255) begin
            n_err++;
            $display("FAIL cnt_saturate got=%0d exp=255", dut.illegal_cnt_q);
        end
`endif
    endtask
    initial begin
        test_reset();
        test_itype();
        test_rtype();
        test_stall_flush();
        test_illegal();
        test_reset_in_stall();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
